// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one registered multiplier among NUM_REQ requesters.
// Latency: grant at T, clear at T+1, enable T+2..T+1+RUN_CYCLES, response valid at T+3+RUN_CYCLES.
// Backpressure: response held in RESP until iRespReady; no grants are issued until it is consumed.
// Option: MUL_SCHED_ZERO_SKIP_EN answers jobs with a zero operand directly (response at T+1).
module mul_sched #(
  parameter int BITWIDTH   = 8,
  parameter int NUM_REQ    = 4,
  parameter int RUN_CYCLES = 256
) (
  input  logic                          iClk,
  input  logic                          iRstN,
  input  logic [NUM_REQ-1:0]            iReqValid,
  input  logic [NUM_REQ*BITWIDTH-1:0]   iReqData0,
  input  logic [NUM_REQ*BITWIDTH-1:0]   iReqData1,
  output logic [NUM_REQ-1:0]            oReqReady,
  output logic                          oMulEn,
  output logic                          oMulClr,
  output logic [BITWIDTH-1:0]           oMulData0,
  output logic [BITWIDTH-1:0]           oMulData1,
  input  logic [2*BITWIDTH-1:0]         iMulData,
  output logic                          oRespValid,
  output logic [$clog2(NUM_REQ)-1:0]    oRespId,
  output logic [2*BITWIDTH-1:0]         oRespData,
  input  logic                          iRespReady,
  output logic                          oBusy
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(RUN_CYCLES + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]          state;
  logic [IDW-1:0]      rrPtr;
  logic [IDW-1:0]      winner;
  logic [IDW-1:0]      scanIdx;
  logic                found;
  logic                grant;
  logic [CNTW-1:0]     runCnt;
  logic [BITWIDTH-1:0] winData0;
  logic [BITWIDTH-1:0] winData1;

  // Round-robin scan starting at rrPtr; the pointer width makes the wrap free.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scanIdx  = '0;
    winData0 = '0;
    winData1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scanIdx = rrPtr + IDW'(i);
      if (!found && iReqValid[scanIdx]) begin
        found  = 1'b1;
        winner = scanIdx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        winData0 = iReqData0[i*BITWIDTH +: BITWIDTH];
        winData1 = iReqData1[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Grant only from IDLE and never while reset is being applied.
  always_comb begin
    grant     = found && iRstN && (state == IDLE);
    oReqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oReqReady[i] = grant && (winner == IDW'(i));
    end
  end

  // Control outputs decoded from the state register, so they clear with it.
  always_comb begin
    oMulClr    = (state == CLEAR);
    oMulEn     = (state == RUN);
    oRespValid = (state == RESP);
    oBusy      = (state != IDLE);
  end

  // Job sequencing, operand/result registers and round-robin pointer.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state     <= IDLE;
      rrPtr     <= '0;
      runCnt    <= '0;
      oMulData0 <= '0;
      oMulData1 <= '0;
      oRespId   <= '0;
      oRespData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            oMulData0 <= winData0;
            oMulData1 <= winData1;
            oRespId   <= winner;
            rrPtr     <= winner + IDW'(1);
`ifdef MUL_SCHED_ZERO_SKIP_EN
            if ((winData0 == '0) || (winData1 == '0)) begin
              oRespData <= '0;
              state     <= RESP;
            end else begin
              state <= CLEAR;
            end
`else
            state <= CLEAR;
`endif
          end
        end
        CLEAR: begin
          runCnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (runCnt == CNTW'(RUN_CYCLES - 1)) begin
            runCnt <= '0;
            state  <= CAPTURE;
          end else begin
            runCnt <= runCnt + 1'b1;
          end
        end
        CAPTURE: begin
          oRespData <= iMulData;
          state     <= RESP;
        end
        RESP: begin
          if (iRespReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter BITWIDTH, default 8, operand width of the shared multiplier_reg.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; SHALL be a power of two, 2..16.
REQ-003 Parameter RUN_CYCLES, default 256, enable cycles per job; SHALL be at least 1.
REQ-004 iClk  input  1  sole clock; all logic on the rising edge.
REQ-005 iRstN  input  1  synchronous, active-low reset.
REQ-006 iReqValid  input  NUM_REQ  per-requester job request.
REQ-007 iReqData0, iReqData1  input  NUM_REQ*BITWIDTH each  packed operands; requester k uses slice k.
REQ-008 oReqReady  output  NUM_REQ  one-hot grant; a job is accepted when iReqValid[k] and oReqReady[k] are both high.
REQ-009 oMulEn, oMulClr  output  1 each  drive multiplier iEn and iClr.
REQ-010 oMulData0, oMulData1  output  BITWIDTH each  latched operands to the multiplier.
REQ-011 iMulData  input  2*BITWIDTH  multiplier oData.
REQ-012 oRespValid, oRespId, oRespData  output  1, clog2(NUM_REQ), 2*BITWIDTH  result channel.
REQ-013 iRespReady  input  1  the result is consumed when oRespValid and iRespReady are both high.
REQ-014 oBusy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, CAPTURE, RESP.
REQ-016 IDLE: if any iReqValid is high, grant exactly one requester combinationally via oReqReady.
- Winner: first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
- Same edge: latch operands into oMulData0/1, latch winner id, set rr_ptr = winner+1 mod NUM_REQ, go to CLEAR.
REQ-017 oReqReady SHALL be all-zero in every state other than IDLE, and when no iReqValid is high.
REQ-018 CLEAR: oMulClr=1 and oMulEn=0 for exactly one cycle, then RUN.
REQ-019 RUN: oMulEn=1 and oMulClr=0 for exactly RUN_CYCLES consecutive cycles, counted by a clog2(RUN_CYCLES+1)-bit counter, then CAPTURE.
REQ-020 CAPTURE: oMulEn=0; register iMulData into oRespData; go to RESP.
REQ-021 RESP: oRespValid=1; oRespId and oRespData held stable until the handshake; then IDLE.
REQ-022 Latency, grant at cycle T: oMulClr at T+1, oMulEn at T+2..T+1+RUN_CYCLES, oRespValid first high at T+3+RUN_CYCLES.
REQ-023 Back-to-back: earliest next grant is the cycle after the response handshake; no overlap of jobs.
REQ-024 oMulData0/1 SHALL stay constant from the grant until the next grant.
REQ-025 Requesters SHALL hold iReqValid and operands until granted; the controller does not track withdrawn requests.
REQ-026 oMulEn and oMulClr SHALL never be high in the same cycle.

Reset
REQ-027 iRstN low at a rising edge, in any state: state=IDLE, rr_ptr=0, counter=0, and every output register cleared to 0.
- Outputs cleared: oMulEn, oMulClr, oMulData0/1, oRespValid, oRespId, oRespData, oBusy.
REQ-028 Reset mid-job drops the job silently; no response is produced.
REQ-029 oReqReady SHALL be 0 in every cycle in which iRstN is low.

Configuration
REQ-030 Macro MUL_SCHED_ZERO_SKIP_EN.
REQ-031 Defined: a granted job with either operand 0 goes IDLE->RESP directly, with oRespData=0 and oRespValid at T+1; CLEAR and RUN are skipped, and oMulEn/oMulClr stay 0.
REQ-032 Undefined: every job, zero operands included, follows the full CLEAR/RUN/CAPTURE sequence.

Verification
Common setup: BITWIDTH=8, NUM_REQ=4, RUN_CYCLES=256; multiplier_reg instantiated or modelled.
REQ-033 Single job: req0 with 10,20 valid at T -> oMulClr at T+1; 256 cycles of oMulEn; oRespValid at T+259 with id 0, data 200.
REQ-034 Round-robin: all four requesters valid continuously, iRespReady=1 -> grant order 0,1,2,3,0; no requester granted twice in any window of 4 grants.
REQ-035 Response backpressure: iRespReady=0 for 20 cycles after oRespValid -> oRespData/oRespId stable, oReqReady all-zero, oBusy=1; accepted on the first high cycle, then IDLE.
REQ-036 Reset mid-RUN: iRstN=0 at cycle 100 of RUN -> next cycle all outputs 0 and state IDLE; no oRespValid for the dropped job.
REQ-037 Zero operand, req2 with 0,55: with MUL_SCHED_ZERO_SKIP_EN -> oRespValid at T+1, data 0, oMulEn never high; without it -> full 259-cycle latency, data 0.
REQ-038 Assertions throughout all scenarios: oReqReady one-hot or zero; oMulEn and oMulClr mutually exclusive.
